// File: rtl/remap_pixel_reader.sv
// Remap pixel reader: takes source coordinates, fetches pixels from frame-buffer BRAM and
// returns them in accept order as a raster-tagged valid/ready stream.
module remap_pixel_reader #(
   parameter int unsigned SRC_W      = 960,
   parameter int unsigned SRC_H      = 1080,
   parameter int unsigned OUT_W      = 1080,
   parameter int unsigned OUT_H      = 960,
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned PIX_W      = 24,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned SKID       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [11:0]       xIn,
   input  logic [11:0]       yIn,
   input  logic              addr_vld,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   input  logic [PIX_W-1:0]  bram_dout,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_vld,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              ovf
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 3) + 1;
   localparam int unsigned OX_W  = $clog2(OUT_W + 1);
   localparam int unsigned OY_W  = $clog2(OUT_H + 1);
   localparam logic [11:0] X_MAX = 12'(SRC_W - 1);
   localparam logic [11:0] Y_MAX = 12'(SRC_H - 1);

   logic [11:0]       x_c;
   logic [11:0]       y_c;
   logic [ADDR_W-1:0] lin_addr;
   logic [RD_LAT-1:0] rd_vld_q;
   logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  inflight_q;
   logic [CNT_W-1:0]  occupancy;
   logic [OX_W-1:0]   ox_q;
   logic [OY_W-1:0]   oy_q;
   logic              push;
   logic              pop;
   logic              full;
   logic              wr_ok;

   // Truncating each operand to ADDR_W keeps the product exact modulo 2**ADDR_W.
   always_comb begin
      x_c      = (xIn > X_MAX) ? X_MAX : xIn;
      y_c      = (yIn > Y_MAX) ? Y_MAX : yIn;
      lin_addr = ADDR_W'(y_c) * ADDR_W'(SRC_W) + ADDR_W'(x_c);
   end

   assign push      = rd_vld_q[RD_LAT-1];
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop       = pix_vld & pix_ready;
   assign wr_ok     = push & (~full | pop);
   assign occupancy = count_q + inflight_q + CNT_W'(addr_vld);

   assign pix_vld = (count_q != '0);
   assign pix_out = pix_vld ? fifo_mem[rd_ptr_q] : '0;
   assign pix_eol = pix_vld & (ox_q == OX_W'(OUT_W - 1));
   assign pix_sof = pix_vld & (ox_q == '0) & (oy_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_ready  <= 1'b0;
         bram_en    <= 1'b0;
         bram_addr  <= '0;
         rd_vld_q   <= '0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf        <= 1'b0;
         ox_q       <= '0;
         oy_q       <= '0;
      end else begin
         mem_ready <= (occupancy <= CNT_W'(FIFO_DEPTH - SKID));
         bram_en   <= addr_vld;
         if (addr_vld) begin
            bram_addr <= lin_addr;
         end
         rd_vld_q[0] <= bram_en;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
         end
         // Dropped pushes still retire from the in-flight count.
         inflight_q <= inflight_q + CNT_W'(addr_vld) - CNT_W'(push);
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(wr_ok) - CNT_W'(pop);
         if (push & full & ~pop) begin
            ovf <= 1'b1;
         end
         if (pop) begin
            if (ox_q == OX_W'(OUT_W - 1)) begin
               ox_q <= '0;
               oy_q <= (oy_q == OY_W'(OUT_H - 1)) ? '0 : oy_q + OY_W'(1);
            end else begin
               ox_q <= ox_q + OX_W'(1);
            end
         end
      end
   end

   // When full, a same-cycle pop frees the head slot that wr_ptr points at.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         fifo_mem[wr_ptr_q] <= bram_dout;
      end
   end

endmodule

// File: tb/tb_remap_pixel_reader.sv
// Bench for remap_pixel_reader: random coordinate streams checked against a queue model of
// in-order fetch, clamp/linear addressing, occupancy-based ready and raster tagging.
module tb_remap_pixel_reader;

   localparam int OUT_W  = 10;
   localparam int OUT_H  = 3;
   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] xIn;
   logic [11:0] yIn;
   logic        addr_vld;
   logic        mem_ready;
   logic [19:0] bram_addr;
   logic        bram_en;
   logic [23:0] bram_dout;
   logic [23:0] pix_out;
   logic        pix_vld;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;
   logic        ovf;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] q[$];
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          pop_idx = 0;
   int          sb_pushes = 0;
   int          sb_cap;
   bit          mr_chk;
   bit          mr_valid = 0;
   bit          mr_exp;
   bit          hold_vld = 0;
   logic [23:0] hold_pix;
   logic [23:0] rd_pipe [RD_LAT];
   int          sent;

   remap_pixel_reader #(
      .OUT_W  (OUT_W),
      .OUT_H  (OUT_H),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .xIn       (xIn),
      .yIn       (yIn),
      .addr_vld  (addr_vld),
      .mem_ready (mem_ready),
      .bram_addr (bram_addr),
      .bram_en   (bram_en),
      .bram_dout (bram_dout),
      .pix_out   (pix_out),
      .pix_vld   (pix_vld),
      .pix_ready (pix_ready),
      .pix_sof   (pix_sof),
      .pix_eol   (pix_eol),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix_of(input logic [19:0] a);
      return {a[3:0] ^ a[19:16], a};
   endfunction

   function automatic logic [19:0] exp_addr(input int x, input int y);
      int xc;
      int yc;
      xc = (x > 959) ? 959 : x;
      yc = (y > 1079) ? 1079 : y;
      return 20'(yc * 960 + xc);
   endfunction

   // Frame-buffer BRAM with RD_LAT cycles of read latency.
   always @(posedge clk) begin
      rd_pipe[0] <= pix_of(bram_addr);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_dout = rd_pipe[RD_LAT-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      addr_vld = 1'b0;
      repeat (n) step();
      reset = 1'b0;
   endtask

   // Scoreboard and occupancy model, sampled mid-cycle on the inputs the next edge will see.
   always @(negedge clk) begin
      if (mr_valid && mr_chk) check_eq("mem_ready", mem_ready, mr_exp);
      if (reset) begin
         mr_exp    = 1'b0;
         acc_cnt   = 0;
         pop_cnt   = 0;
         pop_idx   = 0;
         sb_pushes = 0;
         hold_vld  = 0;
         q.delete();
      end else begin
         if (hold_vld) begin
            check_eq("hold_vld", pix_vld, 1);
            check_eq("hold_pix", pix_out, hold_pix);
         end
         mr_exp = ((acc_cnt + int'(addr_vld) - pop_cnt) <= 12);
         if (pix_vld && pix_ready) begin
            if (q.size() == 0) check_eq("pop_unexpected", pix_vld, 0);
            else check_eq("pix_out", pix_out, q.pop_front());
            check_eq("pix_eol", pix_eol, (pop_idx % OUT_W) == OUT_W - 1);
            check_eq("pix_sof", pix_sof, (pop_idx % (OUT_W * OUT_H)) == 0);
            pop_cnt++;
            pop_idx++;
         end
         if (addr_vld) begin
            acc_cnt++;
            if (sb_pushes < sb_cap) begin
               q.push_back(pix_of(exp_addr(int'(xIn), int'(yIn))));
               sb_pushes++;
            end
         end
         hold_vld = pix_vld && !pix_ready;
         hold_pix = pix_out;
      end
      mr_valid = 1;
   end

   // Producer that registers its valid one cycle after sampling mem_ready when honor=1.
   task automatic stream(input int n, input bit honor, input int vld_pct, input bit rnd_ready,
                         input bit bubble_chk, input int max_cyc, output int n_sent);
      logic mr_s;
      int   cyc;
      n_sent = 0;
      cyc    = 0;
      mr_s   = mem_ready;
      while (n_sent < n && cyc < max_cyc) begin
         if (rnd_ready) pix_ready = ($urandom_range(0, 3) != 0);
         if ((!honor || mr_s) && ($urandom_range(0, 99) < vld_pct)) begin
            addr_vld = 1'b1;
            xIn      = 12'($urandom_range(0, 1100));
            yIn      = 12'($urandom_range(0, 1200));
            n_sent++;
         end else begin
            addr_vld = 1'b0;
         end
         @(negedge clk);
         mr_s = mem_ready;
         if (bubble_chk && pop_idx > 0 && pop_idx < n) check_eq("no_bubble", pix_vld, 1);
         step();
         cyc++;
      end
      addr_vld = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      addr_vld  = 1'b0;
      xIn       = '0;
      yIn       = '0;
      pix_ready = 1'b0;
      sb_cap    = 1 << 30;
      mr_chk    = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_mem_ready", mem_ready, 0);
      check_eq("rst_bram_en", bram_en, 0);
      check_eq("rst_bram_addr", bram_addr, 0);
      check_eq("rst_pix_vld", pix_vld, 0);
      check_eq("rst_pix_out", pix_out, 0);
      check_eq("rst_pix_sof", pix_sof, 0);
      check_eq("rst_pix_eol", pix_eol, 0);
      check_eq("rst_ovf", ovf, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check_eq("mr_low_at_release", mem_ready, 0);
      step();
      @(negedge clk);
      check_eq("mr_rise", mem_ready, 1);

      // Single fetch and latency
      step();
      pix_ready = 1'b1;
      addr_vld  = 1'b1;
      xIn       = 12'd5;
      yIn       = 12'd2;
      for (int c = 1; c <= 4; c++) begin
         step();
         addr_vld = 1'b0;
         @(negedge clk);
         if (c == 1) begin
            check_eq("single_bram_en", bram_en, 1);
            check_eq("single_bram_addr", bram_addr, 1925);
         end
         if (c == 2) check_eq("single_en_pulse", bram_en, 0);
         check_eq("single_latency_vld", pix_vld, c == 4);
      end
      check_eq("single_pix", pix_out, pix_of(20'd1925));
      check_eq("single_sof", pix_sof, 1);

      // Clamp
      step();
      addr_vld = 1'b1;
      xIn      = 12'd1000;
      yIn      = 12'd1100;
      step();
      xIn = 12'd1000;
      yIn = 12'd3;
      @(negedge clk);
      check_eq("clamp_xy", bram_addr, 1036799);
      step();
      addr_vld = 1'b0;
      @(negedge clk);
      check_eq("clamp_x", bram_addr, 3839);
      repeat (8) step();
      check_eq("clamp_drained", q.size(), 0);

      // Backpressure with late arrivals
      pix_ready = 1'b0;
      stream(40, 1'b1, 100, 1'b0, 1'b0, 30, sent);
      check_eq("bp_accepted", sent, 14);
      check_eq("bp_ovf", ovf, 0);
      pix_ready = 1'b1;
      repeat (25) step();
      check_eq("bp_drained", q.size(), 0);
      check_eq("bp_ovf_after", ovf, 0);

      // Overflow: only the first 16 survive
      mr_chk = 1'b0;
      do_reset(2);
      sb_cap    = 16;
      pix_ready = 1'b0;
      stream(20, 1'b0, 100, 1'b0, 1'b0, 40, sent);
      repeat (6) step();
      check_eq("ovf_set", ovf, 1);
      check_eq("ovf_full_vld", pix_vld, 1);
      pix_ready = 1'b1;
      repeat (25) step();
      check_eq("ovf_drained", q.size(), 0);
      check_eq("ovf_sticky", ovf, 1);
      do_reset(2);
      sb_cap = 1 << 30;
      mr_chk = 1'b1;
      @(negedge clk);
      check_eq("ovf_cleared", ovf, 0);
      step();

      // Raster tags across a frame boundary, no bubbles
      pix_ready = 1'b1;
      stream(OUT_W * OUT_H + 2, 1'b1, 100, 1'b0, 1'b1, 200, sent);
      check_eq("raster_sent", sent, OUT_W * OUT_H + 2);
      repeat (10) step();
      check_eq("raster_drained", q.size(), 0);
      check_eq("raster_pops", pop_idx, OUT_W * OUT_H + 2);

      // Mid-stream reset: 5 in FIFO, 3 in flight
      pix_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         addr_vld = 1'b1;
         xIn      = 12'($urandom_range(0, 959));
         yIn      = 12'($urandom_range(0, 1079));
         step();
      end
      addr_vld = 1'b0;
      reset    = 1'b1;
      step();
      @(negedge clk);
      check_eq("midrst_vld", pix_vld, 0);
      check_eq("midrst_mr", mem_ready, 0);
      check_eq("midrst_en", bram_en, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_mr_low", mem_ready, 0);
      step();
      @(negedge clk);
      check_eq("midrst_mr_rise", mem_ready, 1);
      pix_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         @(negedge clk);
         check_eq("midrst_no_stale", pix_vld, 0);
      end
      step();

      // Random traffic with random downstream stalls
      stream(300, 1'b1, 70, 1'b1, 1'b0, 1500, sent);
      pix_ready = 1'b1;
      repeat (30) step();
      check_eq("rand_drained", q.size(), 0);
      check_eq("rand_ovf", ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
